mem_responder: RTL and testbench

Unified instruction/data memory responder for the multicycle MIPS core. It sits on the far side of the controller's memory-control outputs. It accepts one read or write request at a time, inserts a configurable number of wait states, and performs word or byte stores. On completion it returns aligned, sign- or zero-extended load data with a single-cycle ready pulse. The controller stalls its memory states until ready.

---
 rtl/mem_responder_pkg.sv | 36 +++
 rtl/mem_responder_if.sv | 17 +
 rtl/mem_responder_lane_align.sv | 29 ++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings, request record and fault rule for the memory responder.
package mem_pkg;
  typedef enum logic [1:0] {
    MW_NONE    = 2'b00,
    MW_WORD    = 2'b01,
    MW_BYTE    = 2'b10,
    MW_ILLEGAL = 2'b11
  } mw_e;

  typedef enum logic [1:0] {
    LT_WORD      = 2'b00,
    LT_BSIGNED   = 2'b01,
    LT_BUNSIGNED = 2'b10,
    LT_WORD_ALT  = 2'b11
  } lt_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    mw_e         mw;
    lt_e         lt;
  } mem_req_t;

  // Out of range, misaligned word access, or illegal memwrite code.
  function automatic logic req_fault(input logic [31:0] addr, input mw_e mw,
                                     input lt_e lt, input int aw);
    logic word_acc;
    word_acc = (mw == MW_WORD) ||
               (mw == MW_NONE && (lt == LT_WORD || lt == LT_WORD_ALT));
    return ((addr >> (aw + 2)) != 32'd0) ||
           (word_acc && addr[1:0] != 2'b00) ||
           (mw == MW_ILLEGAL);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Core-side request/response bundle of the memory responder.
interface mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  memwrite;
  logic [1:0]  ltype;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, addr, wdata, memwrite, ltype,
                  input  rdata, ready, err, busy);
  modport slave  (input  req, addr, wdata, memwrite, ltype,
                  output rdata, ready, err, busy);
endinterface

// File: rtl/mem_responder_lane_align.sv
// Little-endian byte-lane extract/extend for loads and byte merge for stores.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_lane_i,
  input  lt_e         ltype_i,
  output logic [31:0] ld_data_o,
  input  logic [31:0] st_word_i,
  input  logic [1:0]  st_lane_i,
  input  logic [7:0]  st_byte_i,
  output logic [31:0] st_merged_o
);
  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = ld_word_i[{ld_lane_i, 3'b000} +: 8];
    case (ltype_i)
      LT_BSIGNED:   ld_data_o = {{24{lane_byte[7]}}, lane_byte};
      LT_BUNSIGNED: ld_data_o = {24'd0, lane_byte};
      default:      ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    st_merged_o = st_word_i;
    st_merged_o[{st_lane_i, 3'b000} +: 8] = st_byte_i;
  end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: latch request, wait WAIT_CYCLES,
// then answer with a one-cycle ready pulse; stores commit in RESP.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_req_t    req_q;
  logic [31:0] rdata_q;
  logic        err_q, ready_q;
  logic        accept, resp_en, wr_en, cur_fault;
  logic [31:0] cur_addr, ld_data, st_merged, wr_word;
  mw_e         cur_mw;
  lt_e         cur_lt;

  // With WAIT_CYCLES=0 the response is computed straight from the live inputs.
  always_comb begin
    cur_addr  = (state_q == IDLE) ? bus.addr : req_q.addr;
    cur_mw    = (state_q == IDLE) ? mw_e'(bus.memwrite) : req_q.mw;
    cur_lt    = (state_q == IDLE) ? lt_e'(bus.ltype) : req_q.lt;
    cur_fault = req_fault(cur_addr, cur_mw, cur_lt, AW);
    wr_word   = (req_q.mw == MW_BYTE) ? st_merged : req_q.wdata;
  end

  lane_align u_align (
    .ld_word_i   (mem[cur_addr[AW+1:2]]),
    .ld_lane_i   (cur_addr[1:0]),
    .ltype_i     (cur_lt),
    .ld_data_o   (ld_data),
    .st_word_i   (mem[req_q.addr[AW+1:2]]),
    .st_lane_i   (req_q.addr[1:0]),
    .st_byte_i   (req_q.wdata[7:0]),
    .st_merged_o (st_merged)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    resp_en = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        accept = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
          resp_en = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          resp_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        wr_en   = (req_q.mw == MW_WORD || req_q.mw == MW_BYTE) &&
                  !req_fault(req_q.addr, req_q.mw, req_q.lt, AW);
      end
      default: state_d = IDLE;
    endcase
  end

  // ready/err/rdata are registered on entry to RESP so they are visible during it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= resp_en;
      err_q   <= resp_en & cur_fault;
      if (accept)
        req_q <= '{addr: bus.addr, wdata: bus.wdata,
                   mw: mw_e'(bus.memwrite), lt: lt_e'(bus.ltype)};
      if (resp_en) begin
        if (cur_fault)             rdata_q <= '0;
        else if (cur_mw == MW_NONE) rdata_q <= ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[req_q.addr[AW+1:2]] <= wr_word;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed + random bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(WC), .INIT_FILE("")) u_dut (
    .clk(clk), .reset(rst), .bus(b2.slave));
  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(rst), .bus(b0.slave));

  always #5 clk = ~clk;

  logic [31:0] m_mem [256];
  bit          m_val [256];
  logic [31:0] last_rd;
  bit          last_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed behaviour computed directly from the access rules.
  task automatic model(input logic [1:0] mw, input logic [1:0] lt, input logic [31:0] a,
                       input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                       output bit e_known);
    int w, lane;
    logic [31:0] b;
    bit word_ld;
    w = int'(a[9:2]);
    lane = int'(a % 4);
    word_ld = (mw == 2'd0) && (lt == 2'd0 || lt == 2'd3);
    e_err = (a >= 32'd1024) || (mw == 2'd3) || ((mw == 2'd1 || word_ld) && (a % 4) != 0);
    e_rd = last_rd;
    e_known = last_known;
    if (e_err) begin
      e_rd = 32'd0; e_known = 1'b1;
    end else if (mw == 2'd1) begin
      m_mem[w] = wd; m_val[w] = 1'b1;
    end else if (mw == 2'd2) begin
      m_mem[w] = (m_mem[w] & ~(32'hFF << (8 * lane))) | ({24'd0, wd[7:0]} << (8 * lane));
    end else if (!m_val[w]) begin
      e_known = 1'b0;
    end else begin
      b = (m_mem[w] >> (8 * lane)) & 32'hFF;
      if (lt == 2'd1)      e_rd = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      else if (lt == 2'd2) e_rd = b;
      else                 e_rd = m_mem[w];
    end
    last_rd = e_rd;
    last_known = e_known;
  endtask

  task automatic xact(input logic [1:0] mw, input logic [1:0] lt, input logic [31:0] a,
                      input logic [31:0] wd);
    logic e_err;
    logic [31:0] e_rd;
    bit e_known;
    int n;
    model(mw, lt, a, wd, e_err, e_rd, e_known);
    @(negedge clk);
    b2.req = 1'b1; b2.addr = a; b2.wdata = wd; b2.memwrite = mw; b2.ltype = lt;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      b2.addr = $urandom; b2.wdata = $urandom;
      b2.memwrite = 2'($urandom); b2.ltype = 2'($urandom);
      if (!b2.ready) chk("busy_wait", 32'(b2.busy), 32'd1);
    end while (!b2.ready && n < 12);
    chk("latency", n, WC + 1);
    chk("err", 32'(b2.err), 32'(e_err));
    if (e_known) chk("rdata", b2.rdata, e_rd);
    b2.req = 1'b0;
    @(posedge clk); #1;
    chk("ready_pulse", 32'(b2.ready), 32'd0);
    chk("err_idle", 32'(b2.err), 32'd0);
    chk("busy_idle", 32'(b2.busy), 32'd0);
  endtask

  logic [1:0]  rmw, rlt;
  logic [31:0] ra;
  int          seen, sel;

  initial begin
    rst = 1'b1;
    b2.req = 1'b0; b2.addr = '0; b2.wdata = '0; b2.memwrite = '0; b2.ltype = '0;
    b0.req = 1'b0; b0.addr = '0; b0.wdata = '0; b0.memwrite = '0; b0.ltype = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(b2.ready), 32'd0);
    chk("rst_err", 32'(b2.err), 32'd0);
    chk("rst_rdata", b2.rdata, 32'd0);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst0_busy", 32'(b0.busy), 32'd0);
    chk("rst0_rdata", b0.rdata, 32'd0);
    last_rd = 32'd0; last_known = 1'b1;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 16; i++) xact(2'd1, 2'd0, 32'(i * 4), $urandom);

    xact(2'd1, 2'd0, 32'h10, 32'hDEADBEEF);
    xact(2'd0, 2'd0, 32'h10, 32'h0);
    xact(2'd2, 2'd0, 32'h11, 32'h00000080);
    xact(2'd0, 2'd0, 32'h10, 32'h0);
    xact(2'd0, 2'd1, 32'h11, 32'h0);
    xact(2'd0, 2'd2, 32'h11, 32'h0);
    xact(2'd0, 2'd0, 32'h12, 32'h0);
    xact(2'd1, 2'd0, 32'h13, 32'h12345678);
    xact(2'd0, 2'd0, 32'h10, 32'h0);
    xact(2'd3, 2'd0, 32'h10, 32'h0);
    xact(2'd0, 2'd0, 32'h400, 32'h0);
    xact(2'd0, 2'd0, 32'h3FC, 32'h0);

    // Store abandoned by a reset during WAIT.
    @(negedge clk);
    b2.req = 1'b1; b2.addr = 32'h20; b2.wdata = 32'hCAFEF00D; b2.memwrite = 2'd1; b2.ltype = 2'd0;
    @(posedge clk); #1;
    chk("abort_busy_pre", 32'(b2.busy), 32'd1);
    @(negedge clk); rst = 1'b1; b2.req = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_post", 32'(b2.busy), 32'd0);
    chk("abort_ready", 32'(b2.ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; seen += int'(b2.ready); end
    chk("abort_no_resp", seen, 32'd0);
    last_rd = 32'd0; last_known = 1'b1;
    xact(2'd0, 2'd0, 32'h20, 32'h0);

    repeat (40) begin
      sel = $urandom_range(0, 9);
      rmw = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      rlt = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h3F8 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 63));
      xact(rmw, rlt, ra, $urandom);
    end

    // Zero-wait instance, req held high across two requests.
    @(negedge clk);
    b0.req = 1'b1; b0.memwrite = 2'd1; b0.ltype = 2'd0; b0.addr = 32'h10; b0.wdata = 32'hA5A50010;
    seen = 0;
    @(posedge clk); #1;
    chk("w0_rdy_c1", 32'(b0.ready), 32'd1);
    chk("w0_busy_c1", 32'(b0.busy), 32'd1);
    seen += int'(b0.ready);
    b0.addr = 32'h14; b0.wdata = 32'h5A5A0014;
    @(posedge clk); #1;
    chk("w0_rdy_c2", 32'(b0.ready), 32'd0);
    chk("w0_busy_c2", 32'(b0.busy), 32'd0);
    @(posedge clk); #1;
    chk("w0_rdy_c3", 32'(b0.ready), 32'd1);
    seen += int'(b0.ready);
    b0.req = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen += int'(b0.ready); end
    chk("w0_resp_count", seen, 32'd2);

    @(negedge clk);
    b0.req = 1'b1; b0.memwrite = 2'd0; b0.ltype = 2'd0; b0.addr = 32'h10;
    @(posedge clk); #1;
    chk("w0_ld1_rdy", 32'(b0.ready), 32'd1);
    chk("w0_ld1_data", b0.rdata, 32'hA5A50010);
    b0.addr = 32'h14;
    @(posedge clk); #1;
    chk("w0_ld_gap", 32'(b0.ready), 32'd0);
    @(posedge clk); #1;
    chk("w0_ld2_rdy", 32'(b0.ready), 32'd1);
    chk("w0_ld2_data", b0.rdata, 32'h5A5A0014);
    chk("w0_ld2_err", 32'(b0.err), 32'd0);
    b0.req = 1'b0;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
